// File: rtl/hdc_pkg.sv
// Shared types and default widths for the hard drive transfer controller.
package hdc_pkg;
  localparam int DATA_W_D     = 32;
  localparam int TRACK_W_D    = 7;
  localparam int SECTOR_W_D   = 14;
  localparam int TRACKS_D     = 128;
  localparam int SECTORS_D    = 16;
  localparam int MEM_ADDR_W_D = 10;
  localparam int COUNT_W_D    = 14;

  localparam logic DIR_HD_TO_MEM = 1'b0;
  localparam logic DIR_MEM_TO_HD = 1'b1;

  typedef enum logic [1:0] {IDLE, FETCH, STORE, DONE} hdc_state_t;
endpackage

// File: rtl/hdc_addr_gen.sv
// Track/sector/memory address counters with load and advance controls.
module hdc_addr_gen
  import hdc_pkg::*;
#(
  parameter int TRACK_W    = TRACK_W_D,
  parameter int SECTOR_W   = SECTOR_W_D,
  parameter int MEM_ADDR_W = MEM_ADDR_W_D,
  parameter int TRACKS     = TRACKS_D,
  parameter int SECTORS    = SECTORS_D
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  i_load,
  input  logic                  i_adv,
  input  logic [TRACK_W-1:0]    i_track,
  input  logic [SECTOR_W-1:0]   i_sector,
  input  logic [MEM_ADDR_W-1:0] i_mem_addr,
  output logic [TRACK_W-1:0]    o_track,
  output logic [SECTOR_W-1:0]   o_sector,
  output logic [MEM_ADDR_W-1:0] o_mem_addr,
  output logic                  o_sector_wrap,
  output logic                  o_track_ovf
);
  logic [TRACK_W-1:0]    r_track;
  logic [SECTOR_W-1:0]   r_sector;
  logic [MEM_ADDR_W-1:0] r_mem_addr;
  logic                  w_sector_wrap;

  assign w_sector_wrap = (32'(r_sector) == SECTORS - 1);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_track    <= '0;
      r_sector   <= '0;
      r_mem_addr <= '0;
    end else if (i_load) begin
      r_track    <= i_track;
      r_sector   <= i_sector;
      r_mem_addr <= i_mem_addr;
    end else if (i_adv) begin
      r_mem_addr <= r_mem_addr + MEM_ADDR_W'(1);
      if (w_sector_wrap) begin
        r_sector <= '0;
        r_track  <= r_track + TRACK_W'(1);
      end else begin
        r_sector <= r_sector + SECTOR_W'(1);
      end
    end
  end

  // Overflow means the advance just stepped past the last valid track.
  assign o_track_ovf   = w_sector_wrap && (32'(r_track) == TRACKS - 1);
  assign o_sector_wrap = w_sector_wrap;
  assign o_track       = r_track;
  assign o_sector      = r_sector;
  assign o_mem_addr    = r_mem_addr;
endmodule

// File: rtl/hd_transfer_controller.sv
// Block mover between hard drive and data memory, one word per FETCH/STORE pair.
// Optional running checksum of transferred words when HDC_CHECKSUM_EN is defined.
module hd_transfer_controller
  import hdc_pkg::*;
#(
  parameter int DATA_W     = DATA_W_D,
  parameter int TRACK_W    = TRACK_W_D,
  parameter int SECTOR_W   = SECTOR_W_D,
  parameter int TRACKS     = TRACKS_D,
  parameter int SECTORS    = SECTORS_D,
  parameter int MEM_ADDR_W = MEM_ADDR_W_D,
  parameter int COUNT_W    = COUNT_W_D
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  dir,
  input  logic [TRACK_W-1:0]    cmd_track,
  input  logic [SECTOR_W-1:0]   cmd_sector,
  input  logic [MEM_ADDR_W-1:0] cmd_mem_addr,
  input  logic [COUNT_W-1:0]    cmd_count,
  output logic [TRACK_W-1:0]    track,
  output logic [SECTOR_W-1:0]   sector,
  output logic [DATA_W-1:0]     data_write,
  output logic                  flag_write_hd,
  input  logic [DATA_W-1:0]     output_hard_drive,
  output logic [MEM_ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0]     mem_data_out,
  output logic                  mem_write,
  input  logic [DATA_W-1:0]     mem_data_in,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [DATA_W-1:0]     checksum
);
  hdc_state_t          r_state, w_state_nxt;
  logic                r_dir;
  logic                r_error;
  logic [COUNT_W-1:0]  r_count;
  logic [DATA_W-1:0]   r_buf;
  logic [COUNT_W-1:0]  w_count_dec;
  logic                w_accept, w_cmd_bad, w_last, w_store;
  logic                w_sector_wrap, w_track_ovf;

  assign w_accept    = (r_state == IDLE) && start;
  assign w_cmd_bad   = (32'(cmd_track) >= TRACKS) || (32'(cmd_sector) >= SECTORS);
  assign w_count_dec = r_count - COUNT_W'(1);
  assign w_last      = (w_count_dec == '0);
  assign w_store     = (r_state == STORE);

  hdc_addr_gen #(
    .TRACK_W(TRACK_W), .SECTOR_W(SECTOR_W), .MEM_ADDR_W(MEM_ADDR_W),
    .TRACKS(TRACKS), .SECTORS(SECTORS)
  ) u_addr_gen (
    .clock(clock), .reset(reset), .i_load(w_accept), .i_adv(w_store),
    .i_track(cmd_track), .i_sector(cmd_sector), .i_mem_addr(cmd_mem_addr),
    .o_track(track), .o_sector(sector), .o_mem_addr(mem_addr),
    .o_sector_wrap(w_sector_wrap), .o_track_ovf(w_track_ovf)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (start) w_state_nxt = (w_cmd_bad || cmd_count == '0) ? DONE : FETCH;
      FETCH:   w_state_nxt = STORE;
      STORE:   w_state_nxt = (w_last || w_track_ovf) ? DONE : FETCH;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy          = 1'b0;
    done          = 1'b0;
    mem_write     = 1'b0;
    flag_write_hd = 1'b0;
    unique case (r_state)
      FETCH: busy = 1'b1;
      STORE: begin
        busy          = 1'b1;
        mem_write     = (r_dir == DIR_HD_TO_MEM);
        flag_write_hd = (r_dir == DIR_MEM_TO_HD);
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  // Error on overflow only when another word was still due; the final word may land on the last sector.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_dir   <= DIR_HD_TO_MEM;
      r_count <= '0;
      r_error <= 1'b0;
      r_buf   <= '0;
    end else begin
      if (w_accept) begin
        r_dir   <= dir;
        r_count <= cmd_count;
        r_error <= w_cmd_bad;
      end else if (w_store) begin
        r_count <= w_count_dec;
        if (!w_last && w_track_ovf) r_error <= 1'b1;
      end
      if (r_state == FETCH)
        r_buf <= (r_dir == DIR_MEM_TO_HD) ? mem_data_in : output_hard_drive;
    end
  end

  assign data_write   = r_buf;
  assign mem_data_out = r_buf;
  assign error        = r_error;

`ifdef HDC_CHECKSUM_EN
  logic [DATA_W-1:0] r_checksum;
  always_ff @(posedge clock or posedge reset) begin
    if (reset)         r_checksum <= '0;
    else if (w_accept) r_checksum <= '0;
    else if (w_store)  r_checksum <= r_checksum + r_buf;
  end
  assign checksum = r_checksum;
`else
  assign checksum = '0;
`endif
endmodule

// File: tb/tb_hd_transfer_controller.sv
// Scoreboard bench: linear-sector reference model queues expected writes/done, a monitor checks them.
module tb_hd_transfer_controller;
  import hdc_pkg::*;
  localparam int NSEC = TRACKS_D * SECTORS_D;

  logic        clock = 1'b0, reset = 1'b1, start = 1'b0, dir = 1'b0;
  logic [6:0]  cmd_track = '0;
  logic [13:0] cmd_sector = '0;
  logic [9:0]  cmd_mem_addr = '0;
  logic [13:0] cmd_count = '0;
  logic [6:0]  track;
  logic [13:0] sector;
  logic [31:0] data_write, output_hard_drive, mem_data_out, mem_data_in, checksum;
  logic [9:0]  mem_addr;
  logic        flag_write_hd, mem_write, busy, done, error;

  typedef struct {
    int          kind;   // 0 mem write, 1 disk write, 2 done
    int          t, s, ma, cyc;
    logic [31:0] data, csum;
    logic        err;
  } exp_t;
  exp_t q[$];

  logic [31:0] emu_mem [1024];
  logic [31:0] emu_disk[NSEC];
  logic [31:0] ref_mem [1024];
  logic [31:0] ref_disk[NSEC];
  int checks = 0, errors = 0, cyc = 0, writes_seen = 0, dones_seen = 0;

  hd_transfer_controller dut (
    .clock(clock), .reset(reset), .start(start), .dir(dir),
    .cmd_track(cmd_track), .cmd_sector(cmd_sector), .cmd_mem_addr(cmd_mem_addr),
    .cmd_count(cmd_count), .track(track), .sector(sector), .data_write(data_write),
    .flag_write_hd(flag_write_hd), .output_hard_drive(output_hard_drive),
    .mem_addr(mem_addr), .mem_data_out(mem_data_out), .mem_write(mem_write),
    .mem_data_in(mem_data_in), .busy(busy), .done(done), .error(error),
    .checksum(checksum)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  assign mem_data_in       = emu_mem[mem_addr];
  assign output_hard_drive = (sector < 14'd16) ? emu_disk[int'(track) * 16 + int'(sector)] : 32'h0;

  always @(posedge clock) begin
    if (mem_write) emu_mem[mem_addr] <= mem_data_out;
    if (flag_write_hd && sector < 14'd16) emu_disk[int'(track) * 16 + int'(sector)] <= data_write;
  end

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  always @(negedge clock) begin
    exp_t e;
    int   ka;
    if (!reset && (mem_write || flag_write_hd || done)) begin
      ka = mem_write ? 0 : (flag_write_hd ? 1 : 2);
      chk("one_event", 32'(mem_write) + 32'(flag_write_hd) + 32'(done), 1);
      if (ka == 2) dones_seen++;
      if (q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_event: got kind %0d at cycle %0d expected none", ka, cyc);
      end else begin
        e = q.pop_front();
        chk("event_kind", ka, e.kind);
        chk("event_cycle", cyc, e.cyc);
        if (e.kind == 2) begin
          chk("done_error", error, e.err);
          chk("done_checksum", checksum, e.csum);
          chk("done_busy", busy, 0);
        end else begin
          chk("write_busy", busy, 1);
          if (e.kind == 0) begin
            chk("mem_addr", mem_addr, e.ma);
            chk("mem_data", mem_data_out, e.data);
            ref_mem[e.ma] = e.data;
          end else begin
            chk("hd_track", track, e.t);
            chk("hd_sector", sector, e.s);
            chk("hd_data", data_write, e.data);
            ref_disk[e.t * 16 + e.s] = e.data;
          end
          writes_seen++;
        end
      end
    end
  end

  // Reference: words occupy consecutive linear sectors track*16+sector; running off sector 2047 is an error.
  task automatic issue(input logic d, input int t, input int s, input int ma, input int cnt, input bit wt);
    int T, k, lin, n, d0;
    logic [31:0] sum;
    bit bad;
    exp_t e;
    n = 0;
    while ((busy || done) && n < 100) begin @(negedge clock); n++; end
    d0  = dones_seen;
    T   = cyc + 1;
    bad = (t >= TRACKS_D) || (s >= SECTORS_D);
    sum = '0;
    k   = 0;
    if (!bad) begin
      lin = t * SECTORS_D + s;
      for (int i = 0; i < cnt; i++) begin
        if (lin + i >= NSEC) begin bad = 1; break; end
        e.kind = d ? 1 : 0;
        e.ma   = (ma + i) % 1024;
        e.t    = (lin + i) / SECTORS_D;
        e.s    = (lin + i) % SECTORS_D;
        e.data = d ? ref_mem[e.ma] : ref_disk[lin + i];
        e.cyc  = T + 1 + 2 * i;
        e.csum = '0;
        e.err  = 1'b0;
        sum   += e.data;
        q.push_back(e);
        k++;
      end
    end
    e.kind = 2; e.t = 0; e.s = 0; e.ma = 0; e.data = '0;
    e.cyc  = T + 2 * k;
    e.err  = bad;
`ifdef HDC_CHECKSUM_EN
    e.csum = sum;
`else
    e.csum = '0;
`endif
    q.push_back(e);
    dir = d; cmd_track = 7'(t); cmd_sector = 14'(s); cmd_mem_addr = 10'(ma); cmd_count = 14'(cnt);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    if (wt) begin
      n = 0;
      while (dones_seen == d0 && n < 2 * cnt + 20) begin @(negedge clock); n++; end
      if (dones_seen == d0) begin
        checks++; errors++;
        $display("FAIL done_timeout: got no done after %0d cycles expected done", n);
      end
      chk("queue_drained", q.size(), 0);
    end
  endtask

  task automatic chk_outputs_zero(string tag);
    chk({tag, "_track"}, track, 0);
    chk({tag, "_sector"}, sector, 0);
    chk({tag, "_mem_addr"}, mem_addr, 0);
    chk({tag, "_data_write"}, data_write, 0);
    chk({tag, "_mem_data_out"}, mem_data_out, 0);
    chk({tag, "_flag_write_hd"}, flag_write_hd, 0);
    chk({tag, "_mem_write"}, mem_write, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_error"}, error, 0);
    chk({tag, "_checksum"}, checksum, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got simulation still running expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n, w0;
    logic [31:0] v;
    for (int i = 0; i < 1024; i++) begin v = $urandom; emu_mem[i] = v; ref_mem[i] = v; end
    for (int i = 0; i < NSEC; i++) begin v = $urandom; emu_disk[i] = v; ref_disk[i] = v; end
    emu_disk[0] = 32'h6C000000; ref_disk[0] = 32'h6C000000;
    emu_disk[1] = 32'h80400000; ref_disk[1] = 32'h80400000;
    for (int i = 0; i < 4; i++) begin
      emu_disk[160 + i] = 32'(i + 1); ref_disk[160 + i] = 32'(i + 1);
    end

    repeat (3) @(negedge clock);
    chk_outputs_zero("reset");
    reset = 1'b0;
    @(negedge clock);

    issue(1'b0, 0, 0, 0, 10, 1);
    issue(1'b1, 3, 14, 10'h3FE, 4, 1);
    chk("no_error_after_wrap", error, 0);
    issue(1'b0, 127, 14, 10'h050, 5, 1);
    chk("error_sticky", error, 1);
    issue(1'b0, 9, 5, 10'h123, 0, 1);
    issue(1'b1, 5, 16, 10'h040, 3, 1);
    issue(1'b0, 10, 0, 10'h100, 4, 1);

    // Second start while busy must be ignored; then abort mid-transfer with reset.
    w0 = writes_seen;
    issue(1'b0, 20, 3, 10'h200, 6, 0);
    repeat (3) @(negedge clock);
    dir = 1'b1; cmd_count = 14'd2; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    n = 0;
    while (writes_seen < w0 + 2 && n < 20) begin @(negedge clock); n++; end
    chk("writes_before_reset", writes_seen - w0, 2);
    @(negedge clock);
    reset = 1'b1;
    q.delete();
    #1;
    chk_outputs_zero("abort");
    @(negedge clock);
    chk_outputs_zero("abort_hold");
    reset = 1'b0;
    @(negedge clock);
    issue(1'b1, 40, 7, 10'h0F0, 5, 1);

    for (int r = 0; r < 30; r++) begin
      int t, s;
      t = ($urandom_range(0, 3) == 0) ? $urandom_range(124, 127) : $urandom_range(0, 127);
      s = ($urandom_range(0, 7) == 0) ? $urandom_range(16, 40) : $urandom_range(0, 15);
      issue(1'($urandom_range(0, 1)), t, s, $urandom_range(0, 1023), $urandom_range(0, 12), 1);
    end

    repeat (4) @(negedge clock);
    chk("final_queue_empty", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
